// File: rtl/reset_sequencer.sv
// Power-on / external / software reset sequencer: holds all channels in reset, then
// releases them one at a time with a fixed stagger and reports the last reset cause.
module reset_sequencer #(
    parameter int NCH         = 2,
    parameter int HOLD_CYC    = 255,
    parameter int STAGGER_CYC = 16,
    parameter int DEBOUNCE    = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           ext_rst_req,
    input  logic           sw_rst,
    output logic [NCH-1:0] rst_out,
    output logic           ready,
    output logic [1:0]     cause
);

    localparam int HW  = $clog2(HOLD_CYC + 1);
    localparam int STW = $clog2(STAGGER_CYC + 1);
    localparam int DW  = $clog2(DEBOUNCE + 1);

    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [STW-1:0] STAG_LAST = STW'(STAGGER_CYC - 1);
    localparam logic [DW-1:0]  DEB_MAX   = DW'(DEBOUNCE);

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_EXT = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;

    typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;

    logic [1:0]     por_sync_q;
    logic [1:0]     ext_sync_q;
    logic [DW-1:0]  deb_q, deb_d;
    logic           ext_valid;

    state_t         state_q, state_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [STW-1:0] stag_q, stag_d;
    logic [NCH-1:0] rst_q, rst_d;
    logic           ready_q, ready_d;
    logic [1:0]     cause_q, cause_d;
    logic [NCH-1:0] rst_shifted;

    // Synchronizers and debounce run from reset_n alone so the request path is live
    // as soon as the master reset deasserts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            por_sync_q <= 2'b00;
            ext_sync_q <= 2'b00;
            deb_q      <= '0;
        end else begin
            por_sync_q <= {por_sync_q[0], 1'b1};
            ext_sync_q <= {ext_sync_q[0], ext_rst_req};
            deb_q      <= deb_d;
        end
    end

    always_comb begin
        deb_d = deb_q;
        if (!ext_sync_q[1]) begin
            deb_d = '0;
        end else if (deb_q != DEB_MAX) begin
            deb_d = deb_q + 1'b1;
        end
    end

    assign ext_valid = (deb_q == DEB_MAX);

    // Channels release LSB first, so each release step is a left shift of the mask.
    assign rst_shifted = rst_q << 1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= HOLD;
            hold_q  <= '0;
            stag_q  <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
            cause_q <= CAUSE_POR;
        end else if (!por_sync_q[1]) begin
            state_q <= HOLD;
            hold_q  <= '0;
            stag_q  <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
            cause_q <= CAUSE_POR;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            stag_q  <= stag_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        stag_d  = stag_q;
        rst_d   = rst_q;
        ready_d = ready_q;
        cause_d = cause_q;

        // A restart keeps the hold counter pinned at 0 while the request stays valid.
        if (ext_valid || (state_q == RUN && sw_rst)) begin
            state_d = HOLD;
            hold_d  = '0;
            stag_d  = '0;
            rst_d   = '1;
            ready_d = 1'b0;
            cause_d = ext_valid ? CAUSE_EXT : CAUSE_SW;
        end else begin
            case (state_q)
                HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        rst_d  = rst_shifted;
                        hold_d = '0;
                        stag_d = '0;
                        if (rst_shifted == '0) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                        end else begin
                            state_d = RELEASE;
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                RELEASE: begin
                    if (stag_q == STAG_LAST) begin
                        rst_d  = rst_shifted;
                        stag_d = '0;
                        if (rst_shifted == '0) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                        end
                    end else begin
                        stag_d = stag_q + 1'b1;
                    end
                end
                RUN: begin
                    state_d = RUN;
                end
                default: begin
                    state_d = HOLD;
                end
            endcase
        end
    end

    assign rst_out = rst_q;
    assign ready   = ready_q;
    assign cause   = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with NCH=3, HOLD_CYC=8, STAGGER_CYC=4, DEBOUNCE=3.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       ext_rst_req = 1'b0;
    logic       sw_rst = 1'b0;
    logic [2:0] rst_out;
    logic       ready;
    logic [1:0] cause;

    int tests = 0;
    int fails = 0;

    reset_sequencer #(
        .NCH(3), .HOLD_CYC(8), .STAGGER_CYC(4), .DEBOUNCE(3)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ext_rst_req(ext_rst_req), .sw_rst(sw_rst),
        .rst_out(rst_out), .ready(ready), .cause(cause)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drops reset_n mid-cycle, checks the asynchronous values, then checks the release timeline.
    task automatic do_por(input string tag);
        logic [3:0] exp;
        reset_n = 1'b0;
        #1;
        tests++;
        if ({ready, rst_out, cause} !== 6'b0_111_00) begin
            fails++;
            $display("FAIL %s_async: got rdy/rst/cause=%b/%b/%b expected 0/111/00", tag, ready, rst_out, cause);
        end
        repeat (5) tick();
        tests++;
        if ({ready, rst_out, cause} !== 6'b0_111_00) begin
            fails++;
            $display("FAIL %s_low: got rdy/rst/cause=%b/%b/%b expected 0/111/00", tag, ready, rst_out, cause);
        end
        reset_n = 1'b1;
        // T0 is the second edge after reset_n rises; releases at T0+8, +12, +16.
        for (int n = 1; n <= 20; n++) begin
            tick();
            exp = {(n >= 18), (n < 18), (n < 14), (n < 10)};
            tests++;
            if ({ready, rst_out} !== exp) begin
                fails++;
                $display("FAIL %s_seq edge %0d: got rdy/rst=%b/%b expected %b/%b", tag, n, ready, rst_out, exp[3], exp[2:0]);
            end
        end
        tests++;
        if (cause !== 2'b00) begin
            fails++;
            $display("FAIL %s_cause: got %b expected 00", tag, cause);
        end
    endtask

    task automatic test_reset;
        do_por("por");
    endtask

    task automatic test_sw;
        logic [3:0] exp;
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        tests++;
        if ({ready, rst_out, cause} !== 6'b0_111_10) begin
            fails++;
            $display("FAIL sw_start: got rdy/rst/cause=%b/%b/%b expected 0/111/10", ready, rst_out, cause);
        end
        for (int m = 1; m <= 17; m++) begin
            if (m == 3) sw_rst = 1'b1;
            tick();
            sw_rst = 1'b0;
            exp = {(m >= 16), (m < 16), (m < 12), (m < 8)};
            tests++;
            if ({ready, rst_out} !== exp) begin
                fails++;
                $display("FAIL sw_seq edge %0d: got rdy/rst=%b/%b expected %b/%b", m, ready, rst_out, exp[3], exp[2:0]);
            end
        end
    endtask

    task automatic test_ext_debounce;
        ext_rst_req = 1'b1;
        tick();
        tick();
        ext_rst_req = 1'b0;
        repeat (8) tick();
        tests++;
        if ({ready, rst_out, cause} !== 6'b1_000_10) begin
            fails++;
            $display("FAIL ext_short: got rdy/rst/cause=%b/%b/%b expected 1/000/10", ready, rst_out, cause);
        end
        ext_rst_req = 1'b1;
        for (int t = 1; t <= 22; t++) begin
            if (t == 4) ext_rst_req = 1'b0;
            tick();
            if (t == 5) begin
                tests++;
                if (rst_out !== 3'b000) begin
                    fails++;
                    $display("FAIL ext_pre: got rst=%b expected 000", rst_out);
                end
            end
            if (t == 6) begin
                tests++;
                if ({ready, rst_out, cause} !== 6'b0_111_01) begin
                    fails++;
                    $display("FAIL ext_valid: got rdy/rst/cause=%b/%b/%b expected 0/111/01", ready, rst_out, cause);
                end
            end
            if (t == 14) begin
                tests++;
                if (rst_out !== 3'b110) begin
                    fails++;
                    $display("FAIL ext_bit0: got rst=%b expected 110", rst_out);
                end
            end
            if (t == 22) begin
                tests++;
                if ({ready, rst_out, cause} !== 6'b1_000_01) begin
                    fails++;
                    $display("FAIL ext_done: got rdy/rst/cause=%b/%b/%b expected 1/000/01", ready, rst_out, cause);
                end
            end
        end
    endtask

    task automatic test_ext_held;
        for (int t = 1; t <= 40; t++) begin
            ext_rst_req = (t <= 20);
            tick();
            if (t == 6 || t == 20 || t == 30) begin
                tests++;
                if ({ready, rst_out} !== 4'b0111) begin
                    fails++;
                    $display("FAIL held_hold edge %0d: got rdy/rst=%b/%b expected 0/111", t, ready, rst_out);
                end
            end
            if (t == 31) begin
                tests++;
                if (rst_out !== 3'b110) begin
                    fails++;
                    $display("FAIL held_bit0: got rst=%b expected 110", rst_out);
                end
            end
            if (t == 39) begin
                tests++;
                if ({ready, rst_out} !== 4'b1000) begin
                    fails++;
                    $display("FAIL held_done: got rdy/rst=%b/%b expected 1/000", ready, rst_out);
                end
            end
        end
        ext_rst_req = 1'b0;
    endtask

    task automatic test_back_to_back;
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        repeat (17) tick();
        tests++;
        if ({ready, rst_out, cause} !== 6'b1_000_10) begin
            fails++;
            $display("FAIL b2b_sw: got rdy/rst/cause=%b/%b/%b expected 1/000/10", ready, rst_out, cause);
        end
        // The third synchronized ext sample lands with sw_rst on edge 6.
        for (int t = 1; t <= 22; t++) begin
            ext_rst_req = (t <= 3);
            sw_rst = (t == 6);
            tick();
            sw_rst = 1'b0;
            if (t == 6) begin
                tests++;
                if ({ready, rst_out, cause} !== 6'b0_111_01) begin
                    fails++;
                    $display("FAIL simul_cause: got rdy/rst/cause=%b/%b/%b expected 0/111/01", ready, rst_out, cause);
                end
            end
            if (t == 13 || t == 14) begin
                tests++;
                if (rst_out !== ((t == 13) ? 3'b111 : 3'b110)) begin
                    fails++;
                    $display("FAIL simul_restart edge %0d: got rst=%b expected %b", t, rst_out, (t == 13) ? 3'b111 : 3'b110);
                end
            end
            if (t == 22) begin
                tests++;
                if ({ready, rst_out} !== 4'b1000) begin
                    fails++;
                    $display("FAIL simul_done: got rdy/rst=%b/%b expected 1/000", ready, rst_out);
                end
            end
        end
        ext_rst_req = 1'b0;
    endtask

    task automatic test_mid_release_por;
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        repeat (9) tick();
        tests++;
        if ({ready, rst_out} !== 4'b0110) begin
            fails++;
            $display("FAIL midpor_pre: got rdy/rst=%b/%b expected 0/110", ready, rst_out);
        end
        do_por("midpor");
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        #3;
        test_reset();
        test_sw();
        test_ext_debounce();
        test_ext_held();
        test_back_to_back();
        test_mid_release_por();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
